// File: rtl/sparam_sweep_seq.sv
// S-parameter sweep sequencer: steps LO frequency (outer) and source port (inner), handshaking retune, settle and capture.
// Optional SPSEQ_PORT_MASK_EN adds port_mask so disabled source ports are skipped; otherwise all NPORTS ports are excited.
module sparam_sweep_seq #(
  parameter int NPORTS = 4,
  parameter int FW     = 10,
  parameter int SW     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [FW-1:0]     nfreq,
  input  logic [SW-1:0]     settle,
`ifdef SPSEQ_PORT_MASK_EN
  input  logic [NPORTS-1:0] port_mask,
`endif
  output logic              lo_load,
  output logic [FW-1:0]     lo_freq,
  input  logic              lo_locked,
  output logic [1:0]        src_port,
  output logic              src_en,
  output logic              meas_req,
  input  logic              meas_ack,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, TUNE, LOCK, SETTLE, MEAS, NEXT, DONE} state_t;

  state_t            state_q;
  logic [FW-1:0]     nfreq_q, lo_freq_q;
  logic [SW-1:0]     settle_q, cnt_q;
  logic [1:0]        src_port_q;
  logic [NPORTS-1:0] mask_q;
  logic              lo_load_q, src_en_q, meas_req_q, busy_q, done_q, err_q;

  logic [NPORTS-1:0] start_mask_d;
  logic [2:0]        first_d, low_d, nxt_d;

`ifdef SPSEQ_PORT_MASK_EN
  assign start_mask_d = port_mask;
`else
  assign start_mask_d = '1;
`endif

  // Returns {found, port}: lowest enabled port at or above base.
  function automatic logic [2:0] find_port(input logic [NPORTS-1:0] m, input int base);
    logic [2:0] r;
    r = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (m[i] && i >= base) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  always_comb begin
    first_d = find_port(start_mask_d, 0);
    low_d   = find_port(mask_q, 0);
    nxt_d   = find_port(mask_q, int'(src_port_q) + 1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      nfreq_q    <= '0;
      lo_freq_q  <= '0;
      settle_q   <= '0;
      cnt_q      <= '0;
      src_port_q <= '0;
      mask_q     <= '0;
      lo_load_q  <= 1'b0;
      src_en_q   <= 1'b0;
      meas_req_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      lo_load_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      // Abort wins over any handshake sampled in the same cycle.
      if (abort && state_q != IDLE) begin
        state_q    <= IDLE;
        err_q      <= 1'b1;
        src_en_q   <= 1'b0;
        meas_req_q <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (start) begin
            if (nfreq == '0 || !first_d[2]) begin
              done_q <= 1'b1;
            end else begin
              nfreq_q    <= nfreq;
              settle_q   <= settle;
              mask_q     <= start_mask_d;
              lo_freq_q  <= '0;
              src_port_q <= first_d[1:0];
              lo_load_q  <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= TUNE;
            end
          end
          TUNE: state_q <= LOCK;
          LOCK: if (lo_locked) begin
            src_en_q <= 1'b1;
            cnt_q    <= settle_q;
            state_q  <= SETTLE;
          end
          SETTLE: begin
            if (cnt_q == '0) begin
              meas_req_q <= 1'b1;
              state_q    <= MEAS;
            end else begin
              cnt_q <= cnt_q - SW'(1);
            end
          end
          MEAS: if (meas_ack) begin
            meas_req_q <= 1'b0;
            state_q    <= NEXT;
          end
          NEXT: begin
            if (nxt_d[2]) begin
              src_port_q <= nxt_d[1:0];
              cnt_q      <= settle_q;
              state_q    <= SETTLE;
            end else if (lo_freq_q < nfreq_q - FW'(1)) begin
              lo_freq_q  <= lo_freq_q + FW'(1);
              src_port_q <= low_d[1:0];
              src_en_q   <= 1'b0;
              lo_load_q  <= 1'b1;
              state_q    <= TUNE;
            end else begin
              src_en_q <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end
          end
          DONE: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign lo_load  = lo_load_q;
  assign lo_freq  = lo_freq_q;
  assign src_port = src_port_q;
  assign src_en   = src_en_q;
  assign meas_req = meas_req_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
